dual_stepper_driver: RTL

Consumer side of the controller-to-stepper handshake. Latches one step/direction command pair when `dataReady` rises, then drives two step/dir motor pins with fixed-timing pulses. Both axes step concurrently on a shared period. Reasserts `stepperReady` when both axes finish, and tracks the signed absolute step position of each axis. Sits between the SCARA kinematics controller and the external stepper driver ICs.

---
 rtl/stepper_pkg.sv | 23 ++
 rtl/step_channel.sv | 69 ++++++
 rtl/dual_stepper_driver.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/stepper_pkg.sv
// Shared types and default timing for the dual-axis step/dir pulse generator.
package stepper_pkg;

  localparam int DEF_STEP_HIGH_CYCLES   = 50;
  localparam int DEF_STEP_PERIOD_CYCLES = 500;
  localparam int DEF_DIR_SETUP_CYCLES   = 10;
  localparam int DEF_POS_W              = 16;
  localparam int STEPS_W                = 8;

  typedef enum logic [2:0] {
    IDLE,
    DIR_SETUP,
    PULSE_HI,
    PULSE_LO,
    DONE
  } state_e;

  typedef struct packed {
    logic [STEPS_W-1:0] steps;
    logic               dir;
  } step_cmd_t;

endpackage

// File: rtl/step_channel.sv
// One motor axis: remaining-step counter, step pin, registered dir pin and
// signed position, all driven by strobes from the parent sequencer.
module step_channel
  import stepper_pkg::*;
#(
  parameter int POS_W = DEF_POS_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [STEPS_W:0] cmd_i,
  input  logic             fire_i,
  input  logic             drop_i,
  input  logic             clear_i,
  output logic             step_o,
  output logic             dir_o,
  output logic [POS_W-1:0] pos_o,
  output logic             busy_o
);

  step_cmd_t          cmd;
  logic [STEPS_W-1:0] rem_q, rem_d;
  logic               step_q, step_d;
  logic               dir_q, dir_d;
  logic [POS_W-1:0]   pos_q, pos_d;

  assign cmd = step_cmd_t'(cmd_i);

  always_comb begin
    rem_d  = rem_q;
    step_d = step_q;
    dir_d  = dir_q;
    pos_d  = pos_q;
    if (clear_i) begin
      rem_d  = '0;
      step_d = 1'b0;
    end else if (load_i) begin
      rem_d = cmd.steps;
      dir_d = cmd.dir;
    end else if (fire_i && (rem_q != '0)) begin
      // An axis that has run out simply skips this period; its pin stays low.
      rem_d  = rem_q - 1'b1;
      step_d = 1'b1;
      pos_d  = dir_q ? (pos_q + POS_W'(1)) : (pos_q - POS_W'(1));
    end else if (drop_i) begin
      step_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem_q  <= '0;
      step_q <= 1'b0;
      dir_q  <= 1'b0;
      pos_q  <= '0;
    end else begin
      rem_q  <= rem_d;
      step_q <= step_d;
      dir_q  <= dir_d;
      pos_q  <= pos_d;
    end
  end

  assign step_o = step_q;
  assign dir_o  = dir_q;
  assign pos_o  = pos_q;
  assign busy_o = (rem_q != '0);

endmodule

// File: rtl/dual_stepper_driver.sv
// Accepts one step/dir command per dataReady rising edge and plays it out on
// two axes concurrently with fixed dir-setup, step-high and step-period timing.
//
// state     | meaning
// IDLE      | stepperReady high, waiting for a dataReady rising edge
// DIR_SETUP | dir pins settled, step pins low
// PULSE_HI  | step pins high on axes that still had steps at entry
// PULSE_LO  | remainder of the step period, pins low
// DONE      | single cycle before stepperReady returns
module dual_stepper_driver
  import stepper_pkg::*;
#(
  parameter int STEP_HIGH_CYCLES   = DEF_STEP_HIGH_CYCLES,
  parameter int STEP_PERIOD_CYCLES = DEF_STEP_PERIOD_CYCLES,
  parameter int DIR_SETUP_CYCLES   = DEF_DIR_SETUP_CYCLES,
  parameter int POS_W              = DEF_POS_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       steps1,
  input  logic [7:0]       steps2,
  input  logic             dir1,
  input  logic             dir2,
  input  logic             dataReady,
  input  logic             halt,
  output logic             stepperReady,
  output logic             step1_out,
  output logic             step2_out,
  output logic             dir1_out,
  output logic             dir2_out,
  output logic [POS_W-1:0] pos1,
  output logic [POS_W-1:0] pos2,
  output logic             cmd_dropped
);

  localparam int TMR_W = $clog2(STEP_PERIOD_CYCLES + DIR_SETUP_CYCLES);
  localparam logic [TMR_W-1:0] T_SETUP = TMR_W'(DIR_SETUP_CYCLES - 1);
  localparam logic [TMR_W-1:0] T_HI    = TMR_W'(STEP_HIGH_CYCLES - 1);
  localparam logic [TMR_W-1:0] T_LO    = TMR_W'(STEP_PERIOD_CYCLES - STEP_HIGH_CYCLES - 1);

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             dr_q;
  logic             ready_q;
  logic             dropped_q, dropped_d;
  logic             rise;
  logic             load, fire, drop, clear;
  logic             busy1, busy2, any_rem;

  assign rise    = dataReady & ~dr_q;
  assign any_rem = busy1 | busy2;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    load      = 1'b0;
    fire      = 1'b0;
    drop      = 1'b0;
    clear     = 1'b0;
    dropped_d = rise && (state_q != IDLE);
    if (state_q == IDLE) begin
      // A command arriving together with halt is discarded.
      if (rise && !halt) begin
        state_d = DIR_SETUP;
        timer_d = T_SETUP;
        load    = 1'b1;
      end
    end else if (halt) begin
      state_d = IDLE;
      timer_d = '0;
      clear   = 1'b1;
    end else begin
      unique case (state_q)
        DIR_SETUP, PULSE_LO: begin
          if (timer_q != '0) begin
            timer_d = timer_q - 1'b1;
          end else if (any_rem) begin
            state_d = PULSE_HI;
            timer_d = T_HI;
            fire    = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
        PULSE_HI: begin
          if (timer_q != '0) begin
            timer_d = timer_q - 1'b1;
          end else begin
            state_d = PULSE_LO;
            timer_d = T_LO;
            drop    = 1'b1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      dr_q      <= 1'b0;
      ready_q   <= 1'b1;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      dr_q      <= dataReady;
      ready_q   <= (state_d == IDLE);
      dropped_q <= dropped_d;
    end
  end

  step_channel #(.POS_W(POS_W)) u_ch1 (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (load),
    .cmd_i   ({steps1, dir1}),
    .fire_i  (fire),
    .drop_i  (drop),
    .clear_i (clear),
    .step_o  (step1_out),
    .dir_o   (dir1_out),
    .pos_o   (pos1),
    .busy_o  (busy1)
  );

  step_channel #(.POS_W(POS_W)) u_ch2 (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (load),
    .cmd_i   ({steps2, dir2}),
    .fire_i  (fire),
    .drop_i  (drop),
    .clear_i (clear),
    .step_o  (step2_out),
    .dir_o   (dir2_out),
    .pos_o   (pos2),
    .busy_o  (busy2)
  );

  assign stepperReady = ready_q;
  assign cmd_dropped  = dropped_q;

endmodule
